issue_ctrl: RTL

ISSUE_CTRL -- requirements
Module: issue_ctrl

---
 rtl/issue_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// Dual-issue controller: accepts a decoded pair, splits it on intra-pair conflicts
// or load-use hazards, and drives two registered issue lanes in program order.
module issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            s0_valid,
    input  logic            s0_rs1_en,
    input  logic            s0_rs2_en,
    input  logic            s0_we,
    input  logic            s0_mem,
    input  logic [4:0]      s0_rs1,
    input  logic [4:0]      s0_rs2,
    input  logic [4:0]      s0_rd,
    input  logic [XLEN-1:0] s0_pc,
    input  logic            s1_valid,
    input  logic            s1_rs1_en,
    input  logic            s1_rs2_en,
    input  logic            s1_we,
    input  logic            s1_mem,
    input  logic [4:0]      s1_rs1,
    input  logic [4:0]      s1_rs2,
    input  logic [4:0]      s1_rd,
    input  logic [XLEN-1:0] s1_pc,
    input  logic            ex0_load,
    input  logic [4:0]      ex0_rd,
    input  logic            ex1_load,
    input  logic [4:0]      ex1_rd,
    output logic            i0_valid,
    output logic            i0_rs1_en,
    output logic            i0_rs2_en,
    output logic            i0_we,
    output logic            i0_mem,
    output logic [4:0]      i0_rs1,
    output logic [4:0]      i0_rs2,
    output logic [4:0]      i0_rd,
    output logic [XLEN-1:0] i0_pc,
    output logic            i1_valid,
    output logic            i1_rs1_en,
    output logic            i1_rs2_en,
    output logic            i1_we,
    output logic            i1_mem,
    output logic [4:0]      i1_rs1,
    output logic [4:0]      i1_rs2,
    output logic [4:0]      i1_rd,
    output logic [XLEN-1:0] i1_pc
);

    typedef enum logic {RUN, HOLD1} state_t;

    typedef struct packed {
        logic            valid;
        logic            rs1_en;
        logic            rs2_en;
        logic            we;
        logic            mem;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
    } slot_t;

    state_t state, state_d;
    slot_t  s0, s1, held, held_d, lane0, lane0_d, lane1, lane1_d;
    logic   haz0, haz1, haz_held, raw, waw, conflict;

    assign s0 = '{s0_valid, s0_rs1_en, s0_rs2_en, s0_we, s0_mem, s0_rs1, s0_rs2, s0_rd, s0_pc};
    assign s1 = '{s1_valid, s1_rs1_en, s1_rs2_en, s1_we, s1_mem, s1_rs1, s1_rs2, s1_rd, s1_pc};

    // A load still in EX cannot forward yet; x0 never creates a dependency.
    function automatic logic load_use(input slot_t s, input logic l0, input logic [4:0] r0,
                                      input logic l1, input logic [4:0] r1);
        logic h0, h1;
        h0 = l0 && (r0 != 5'd0) && ((s.rs1_en && s.rs1 == r0) || (s.rs2_en && s.rs2 == r0));
        h1 = l1 && (r1 != 5'd0) && ((s.rs1_en && s.rs1 == r1) || (s.rs2_en && s.rs2 == r1));
        return h0 || h1;
    endfunction

    // An idle lane clears its control bits but keeps addresses/PC stable.
    function automatic slot_t idle(input slot_t s);
        slot_t r;
        r        = s;
        r.valid  = 1'b0;
        r.rs1_en = 1'b0;
        r.rs2_en = 1'b0;
        r.we     = 1'b0;
        r.mem    = 1'b0;
        return r;
    endfunction

    assign haz0     = s0.valid && load_use(s0, ex0_load, ex0_rd, ex1_load, ex1_rd);
    assign haz1     = s1.valid && load_use(s1, ex0_load, ex0_rd, ex1_load, ex1_rd);
    assign haz_held = load_use(held, ex0_load, ex0_rd, ex1_load, ex1_rd);

    assign raw = s0.we && (s0.rd != 5'd0) &&
                 ((s1.rs1_en && s1.rs1 == s0.rd) || (s1.rs2_en && s1.rs2 == s0.rd));
    assign waw = s0.we && s1.we && (s0.rd == s1.rd) && (s0.rd != 5'd0);
    assign conflict = s0.valid && s1.valid && (raw || waw || (s0.mem && s1.mem));

    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state;
        held_d   = held;
        lane0_d  = idle(lane0);
        lane1_d  = idle(lane1);
        in_ready = 1'b0;
        if (flush) begin
            state_d = RUN;
            held_d  = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!haz0) begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            if (s0.valid) begin
                                lane0_d = s0;
                                if (s1.valid && (conflict || haz1)) begin
                                    held_d  = s1;
                                    state_d = HOLD1;
                                end else if (s1.valid) begin
                                    lane1_d = s1;
                                end
                            end else if (s1.valid) begin
                                // A lone slot 1 issues on lane 0 unless it must wait on a load.
                                if (haz1) begin
                                    held_d  = s1;
                                    state_d = HOLD1;
                                end else begin
                                    lane0_d = s1;
                                end
                            end
                        end
                    end
                end
                HOLD1: begin
                    if (!haz_held) begin
                        lane0_d = held;
                        held_d  = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            held  <= '0;
            lane0 <= '0;
            lane1 <= '0;
        end else begin
            state <= state_d;
            held  <= held_d;
            lane0 <= lane0_d;
            lane1 <= lane1_d;
        end
    end

    assign {i0_valid, i0_rs1_en, i0_rs2_en, i0_we, i0_mem, i0_rs1, i0_rs2, i0_rd, i0_pc} = lane0;
    assign {i1_valid, i1_rs1_en, i1_rs2_en, i1_we, i1_mem, i1_rs1, i1_rs2, i1_rd, i1_pc} = lane1;

endmodule
